// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode encodings and the
// EX/MEM halt-machine state encoding.
package cpu_pkg;

  localparam int DW = 16;
  localparam int RW = 4;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LHB    = 4'b1010;
  localparam logic [3:0] OP_LLB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/flag_update.sv
// Combinational next-value and update-enable generation for the Z/V/N
// condition flags, selected by opcode.
// Optional feature macro: RED_FLAGS_EN (RED then writes Z and clears N/V).
import cpu_pkg::*;

module flag_update #(
  parameter int DW = cpu_pkg::DW
) (
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] alu_out,
  input  logic          ovfl,
  output logic          z_next,
  output logic          n_next,
  output logic          v_next,
  output logic          z_en,
  output logic          n_en,
  output logic          v_en
);

  // Decode which flags this opcode writes and what values they take.
  always_comb begin
    z_next = (alu_out == '0);
    n_next = alu_out[DW-1];
    v_next = ovfl;
    z_en   = 1'b0;
    n_en   = 1'b0;
    v_en   = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        z_en = 1'b1;
        n_en = 1'b1;
        v_en = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
        z_en = 1'b1;
      end
`ifdef RED_FLAGS_EN
      OP_RED: begin
        n_next = 1'b0;
        v_next = 1'b0;
        z_en   = 1'b1;
        n_en   = 1'b1;
        v_en   = 1'b1;
      end
`endif
      default: begin
        z_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX->MEM pipeline register with Z/V/N condition flags and a two-state
// halt machine that freezes the pipe once HLT has been presented in MEM.
// Optional feature macro: RED_FLAGS_EN (handled inside flag_update).
import cpu_pkg::*;

module ex_mem_flag_stage #(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [3:0]    ex_opcode,
  input  logic [DW-1:0] ex_alu_out,
  input  logic          ex_ovfl,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_reg_wen,
  input  logic          ex_mem_ren,
  input  logic          ex_mem_wen,
  input  logic [DW-1:0] ex_store_data,
  output logic          mem_valid,
  output logic [3:0]    mem_opcode,
  output logic [DW-1:0] mem_alu_out,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_wen,
  output logic          mem_mem_ren,
  output logic          mem_mem_wen,
  output logic [DW-1:0] mem_store_data,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          halted
);

  state_t state;
  logic   slot_valid;
  logic   z_next, n_next, v_next;
  logic   z_en, n_en, v_en;

  assign slot_valid = ex_valid & ~flush;
  assign halted     = (state == ST_HALT);

  flag_update #(.DW(DW)) u_flag_update (
    .opcode  (ex_opcode),
    .alu_out (ex_alu_out),
    .ovfl    (ex_ovfl),
    .z_next  (z_next),
    .n_next  (n_next),
    .v_next  (v_next),
    .z_en    (z_en),
    .n_en    (n_en),
    .v_en    (v_en)
  );

  // Halt machine, MEM slot capture and flag update; halt overrides stall,
  // stall overrides flush, and a retired HLT in MEM moves to HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_RUN;
      mem_valid      <= 1'b0;
      mem_opcode     <= '0;
      mem_alu_out    <= '0;
      mem_rd         <= '0;
      mem_reg_wen    <= 1'b0;
      mem_mem_ren    <= 1'b0;
      mem_mem_wen    <= 1'b0;
      mem_store_data <= '0;
      flag_z         <= 1'b0;
      flag_v         <= 1'b0;
      flag_n         <= 1'b0;
    end else begin
      case (state)
        ST_HALT: begin
          mem_valid <= 1'b0;
        end
        default: begin
          if (mem_valid && (mem_opcode == OP_HLT)) begin
            state     <= ST_HALT;
            mem_valid <= 1'b0;
          end else if (!stall) begin
            mem_valid      <= slot_valid;
            mem_opcode     <= ex_opcode;
            mem_alu_out    <= ex_alu_out;
            mem_rd         <= ex_rd;
            mem_reg_wen    <= ex_reg_wen & slot_valid;
            mem_mem_ren    <= ex_mem_ren & slot_valid;
            mem_mem_wen    <= ex_mem_wen & slot_valid;
            mem_store_data <= ex_store_data;
            if (slot_valid && z_en) flag_z <= z_next;
            if (slot_valid && n_en) flag_n <= n_next;
            if (slot_valid && v_en) flag_v <= v_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed self-checking bench for ex_mem_flag_stage.
// Honours RED_FLAGS_EN so the RED expectations follow the build.
module tb_ex_mem_flag_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_alu_out;
  logic        ex_ovfl;
  logic [3:0]  ex_rd;
  logic        ex_reg_wen;
  logic        ex_mem_ren;
  logic        ex_mem_wen;
  logic [15:0] ex_store_data;
  logic        mem_valid;
  logic [3:0]  mem_opcode;
  logic [15:0] mem_alu_out;
  logic [3:0]  mem_rd;
  logic        mem_reg_wen;
  logic        mem_mem_ren;
  logic        mem_mem_wen;
  logic [15:0] mem_store_data;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic        halted;

  int vectors;
  int miscompares;

  ex_mem_flag_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_alu_out     (ex_alu_out),
    .ex_ovfl        (ex_ovfl),
    .ex_rd          (ex_rd),
    .ex_reg_wen     (ex_reg_wen),
    .ex_mem_ren     (ex_mem_ren),
    .ex_mem_wen     (ex_mem_wen),
    .ex_store_data  (ex_store_data),
    .mem_valid      (mem_valid),
    .mem_opcode     (mem_opcode),
    .mem_alu_out    (mem_alu_out),
    .mem_rd         (mem_rd),
    .mem_reg_wen    (mem_reg_wen),
    .mem_mem_ren    (mem_mem_ren),
    .mem_mem_wen    (mem_mem_wen),
    .mem_store_data (mem_store_data),
    .flag_z         (flag_z),
    .flag_v         (flag_v),
    .flag_n         (flag_n),
    .halted         (halted)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one EX slot's fields.
  task automatic applyStimulus(input logic v, input logic [3:0] op,
                               input logic [15:0] alu, input logic ov,
                               input logic [3:0] rd, input logic rw,
                               input logic mr, input logic mw,
                               input logic [15:0] sd);
    ex_valid      = v;
    ex_opcode     = op;
    ex_alu_out    = alu;
    ex_ovfl       = ov;
    ex_rd         = rd;
    ex_reg_wen    = rw;
    ex_mem_ren    = mr;
    ex_mem_wen    = mw;
    ex_store_data = sd;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlags(input string tag, input logic z, input logic n,
                            input logic v);
    checkOutput({tag, "_z"}, {15'd0, flag_z}, {15'd0, z});
    checkOutput({tag, "_n"}, {15'd0, flag_n}, {15'd0, n});
    checkOutput({tag, "_v"}, {15'd0, flag_v}, {15'd0, v});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_valid", {15'd0, mem_valid}, 16'h0000);
    checkOutput("rst_halted", {15'd0, halted}, 16'h0000);
    checkFlags("rst", 1'b0, 1'b0, 1'b0);

    // ADD with zero result
    applyStimulus(1'b1, 4'h0, 16'h0000, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 16'h1111);
    step();
    checkOutput("add_valid", {15'd0, mem_valid}, 16'h0001);
    checkOutput("add_rd", {12'd0, mem_rd}, 16'h0003);
    checkOutput("add_regwen", {15'd0, mem_reg_wen}, 16'h0001);
    checkOutput("add_sdata", mem_store_data, 16'h1111);
    checkFlags("add0", 1'b1, 1'b0, 1'b0);

    // SUB with negative result and overflow
    applyStimulus(1'b1, 4'h1, 16'h8000, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    checkOutput("sub_alu", mem_alu_out, 16'h8000);
    checkOutput("sub_op", {12'd0, mem_opcode}, 16'h0001);
    checkFlags("sub", 1'b0, 1'b1, 1'b1);

    // RED with zero sum
    applyStimulus(1'b1, 4'h3, 16'h0000, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
`ifdef RED_FLAGS_EN
    checkFlags("red", 1'b1, 1'b0, 1'b0);
`else
    checkFlags("red", 1'b0, 1'b1, 1'b1);
`endif

    // Re-establish N=1, V=1, then XOR zero only touches Z
    applyStimulus(1'b1, 4'h1, 16'h8000, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    applyStimulus(1'b1, 4'h2, 16'h0000, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    checkFlags("xor", 1'b1, 1'b1, 1'b1);

    // Stall with ADD waiting in EX
    stall = 1'b1;
    applyStimulus(1'b1, 4'h0, 16'h1234, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stall_op", {12'd0, mem_opcode}, 16'h0002);
      checkOutput("stall_alu", mem_alu_out, 16'h0000);
      checkOutput("stall_rd", {12'd0, mem_rd}, 16'h0006);
      checkFlags("stall", 1'b1, 1'b1, 1'b1);
    end
    stall = 1'b0;

    // Flushed store
    flush = 1'b1;
    applyStimulus(1'b1, 4'h9, 16'h0005, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 16'hABCD);
    step();
    checkOutput("flush_valid", {15'd0, mem_valid}, 16'h0000);
    checkOutput("flush_memwen", {15'd0, mem_mem_wen}, 16'h0000);
    checkFlags("flush", 1'b1, 1'b1, 1'b1);
    flush = 1'b0;

    // Valid ADD, then stall+flush together holds it
    applyStimulus(1'b1, 4'h0, 16'h0001, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    checkFlags("add1", 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    flush = 1'b1;
    applyStimulus(1'b1, 4'h2, 16'h0000, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    checkOutput("sf_valid", {15'd0, mem_valid}, 16'h0001);
    checkOutput("sf_alu", mem_alu_out, 16'h0001);
    checkFlags("sf", 1'b0, 1'b0, 1'b0);
    stall = 1'b0;

    // Flushed HLT must not halt
    applyStimulus(1'b1, 4'hF, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    checkOutput("fhlt_halted", {15'd0, halted}, 16'h0000);

    // Valid HLT: presented one cycle, then halted and frozen
    applyStimulus(1'b1, 4'hF, 16'h0000, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    checkOutput("hlt_valid", {15'd0, mem_valid}, 16'h0001);
    checkOutput("hlt_op", {12'd0, mem_opcode}, 16'h000F);
    checkOutput("hlt_halted0", {15'd0, halted}, 16'h0000);
    applyStimulus(1'b1, 4'h0, 16'h0000, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("halt_halted", {15'd0, halted}, 16'h0001);
      checkOutput("halt_valid", {15'd0, mem_valid}, 16'h0000);
      checkOutput("halt_rd", {12'd0, mem_rd}, 16'h000A);
      checkFlags("halt", 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset away from a clock edge
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_halted", {15'd0, halted}, 16'h0000);
    checkOutput("arst_op", {12'd0, mem_opcode}, 16'h0000);
    checkOutput("arst_rd", {12'd0, mem_rd}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Back in RUN: capture resumes
    step();
    checkOutput("run_valid", {15'd0, mem_valid}, 16'h0001);
    checkOutput("run_rd", {12'd0, mem_rd}, 16'h000B);
    checkFlags("run", 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem_flag_stage.md
# ex_mem_flag_stage

EX→MEM pipeline register and condition-flag register for the 16-bit CPU. It captures the ALU result from the execute stage (ADD/SUB/XOR/RED/shift/PADDSB paths, including the zero-extended 4-bit RED sum) with its writeback and memory controls, and updates the Z/V/N flags per opcode. It supports stall and flush, and has a two-state halt machine that freezes the pipe after HLT retires into MEM.

## Interface
Parameters:
- DW, 16, datapath width.
- RW, 4, register-index width.

Ports. Clock `clk`, reset `rst`: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all MEM-side registers and flags.
- flush  in  1  kill the instruction entering MEM.
- ex_valid  in  1  EX slot holds a real instruction.
- ex_opcode  in  4  EX opcode.
- ex_alu_out  in  DW  ALU result.
- ex_ovfl  in  1  ALU signed overflow for ADD/SUB.
- ex_rd  in  RW  destination register.
- ex_reg_wen  in  1  register writeback enable.
- ex_mem_ren  in  1  load.
- ex_mem_wen  in  1  store.
- ex_store_data  in  DW  store data.
- mem_valid, mem_opcode, mem_alu_out, mem_rd, mem_reg_wen, mem_mem_ren, mem_mem_wen, mem_store_data  out  matching widths  registered copies.
- flag_z, flag_v, flag_n  out  1 each  condition flags.
- halted  out  1  high in HALT state.

## Operation
- Opcodes: ADD 0000, SUB 0001, XOR 0010, RED 0011, SLL 0100, SRA 0101, ROR 0110, PADDSB 0111, LW 1000, SW 1001, LHB 1010, LLB 1011, B 1100, BR 1101, PCS 1110, HLT 1111.
- Capture: when not stalled and not halted, the MEM registers load the EX fields. mem_valid is set to ex_valid & ~flush.
- When the captured slot is invalid (flush or ~ex_valid), mem_reg_wen, mem_mem_ren and mem_mem_wen load 0. Data fields may load anything.
- Flag update applies only on a valid, non-flushed, non-stalled capture:
  - ADD, SUB: Z = (alu_out == 0), N = alu_out[15], V = ex_ovfl.
  - XOR, SLL, SRA, ROR: Z only. N and V hold.
  - All other opcodes: no flag change, including RED and PADDSB (see Configuration).
- State machine:
  - RUN→HALT on a valid capture of HLT. halted rises the cycle after capture.
  - In HALT, all MEM registers and flags hold. mem_valid is forced to 0 from the first HALT cycle onward, so the HLT slot is presented for exactly one cycle.
  - HALT exits only on rst.
- Precedence, highest first: rst > halted > stall > flush > capture.
  - Stall and flush together: stall wins; everything holds, including mem_valid.
  - A flushed HLT does not halt.

## Timing
- Reset values: all mem_* outputs 0, flag_z/flag_v/flag_n 0, halted 0, state RUN.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Latency: EX inputs appear on mem_* one cycle after the capturing edge. Flags update on the same edge.
- No combinational path from any input to any output.

## Configuration
- `RED_FLAGS_EN`:
  - Defined: RED sets Z = (alu_out == 0) and clears N and V.
  - Undefined: RED leaves all flags unchanged.

## Structure
- Shared package `cpu_pkg` holds the opcode constants, DW, RW, and the state encoding (RUN = 0, HALT = 1).
- One sub-module, `flag_update`: combinational. Inputs are opcode, alu_out and ovfl; outputs are next-flag values and per-flag update enables.

## Test plan
- Reset: rst=1 mid-stream → all outputs 0 immediately (asynchronous), before the next clk edge.
- ADD result 0x0000, ovfl=0 → next cycle Z=1, N=0, V=0. Then SUB result 0x8000, ovfl=1 → Z=0, N=1, V=1.
- RED with ex_alu_out 0x0000 after flags Z=0, N=1, V=1 → flags unchanged without `RED_FLAGS_EN`; Z=1, N=0, V=0 with it.
- XOR result 0 after N=1, V=1 → Z=1, N=1, V=1. Then stall=1 with ADD at EX → mem_* and flags hold for all stalled cycles.
- flush=1 with SW at EX → mem_valid=0, mem_mem_wen=0, flags unchanged. stall=1 and flush=1 together → previous slot held with mem_valid unchanged.
- Valid HLT captured → mem_valid=1 for one cycle, then halted=1 and mem_valid=0. Later ADD inputs are ignored. rst returns state to RUN.
